fp_class_pipe: RTL and testbench

FP_CLASS_PIPE -- requirements
Module: fp_class_pipe

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_lzc.sv | 19 +
 rtl/fp_class_pipe.sv | 164 ++++++++++++++++
 tb/tb_fp_class_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point class encoding: one-hot class vector and the index of
// each class within it.
package fp_pkg;

  localparam int NTYPES    = 6;
  localparam int INF       = 0;
  localparam int SNAN      = 1;
  localparam int QNAN      = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;

  typedef logic [NTYPES-1:0] fp_class_t;

  function automatic fp_class_t class_bit(input int idx);
    return fp_class_t'(1) << idx;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter. An all-zero input returns W.
module fp_lzc #(
  parameter int W = 8
) (
  input  logic [W-1:0]           a_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);

  localparam int CW = $clog2(W + 1);

  // Scan from the LSB upward so the highest set bit writes last and wins.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_class_pipe.sv
// Two-stage floating-point operand classifier: stage 1 classifies and counts
// leading zeros, stage 2 normalises the significand and unbiases the exponent.
module fp_class_pipe
  import fp_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NEXP+NSIG:0]     in_data,
  input  logic                   in_daz,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_sign,
  output logic [NSIG:0]          out_sig,
  output logic [NEXP+1:0]        out_exp,
  output logic [NTYPES-1:0]      out_flags,
  output logic                   out_flushed,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W    = NEXP + NSIG + 1;
  localparam int LW   = $clog2(NSIG + 1);
  localparam int SW   = $clog2(NSIG + 2);
  localparam int BIAS = 2 ** (NEXP - 1) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam logic signed [NEXP+1:0] BIAS_X = (NEXP + 2)'(BIAS);
  localparam logic signed [NEXP+1:0] EMIN_X = (NEXP + 2)'(EMIN);
  localparam logic signed [NEXP+1:0] SPEC_X = (NEXP + 2)'(BIAS + 1);

  // Handshake: a transfer happens on any cycle where valid && ready. Both
  // stages advance together on en; with en low every register holds, so the
  // output data stays stable while out_valid is high and out_ready is low.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic            sign_in;
  logic [NEXP-1:0] exp_in;
  logic [NSIG-1:0] frac_in;
  fp_class_t       cls_d;
  logic [LW-1:0]   lzc;
  logic [SW-1:0]   shift_d;

  assign sign_in = in_data[W-1];
  assign exp_in  = in_data[W-2:NSIG];
  assign frac_in = in_data[NSIG-1:0];

  fp_lzc #(.W(NSIG)) u_lzc (
    .a_i   (frac_in),
    .cnt_o (lzc)
  );

  // One extra position moves the leading one out into the implicit bit.
  assign shift_d = SW'(lzc) + SW'(1);

  always_comb begin
    cls_d = '0;
    if (&exp_in) begin
      if (~|frac_in)             cls_d = class_bit(INF);
      else if (frac_in[NSIG-1]) cls_d = class_bit(QNAN);
      else                      cls_d = class_bit(SNAN);
    end else if (~|exp_in) begin
      if (~|frac_in) cls_d = class_bit(ZERO);
      else           cls_d = class_bit(SUBNORMAL);
    end else begin
      cls_d = class_bit(NORMAL);
    end
  end

  logic            v1_q;
  logic            sign1_q;
  fp_class_t       cls1_q;
  logic [NEXP-1:0] exp1_q;
  logic [NSIG-1:0] frac1_q;
  logic [SW-1:0]   shift1_q;
  logic            daz1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      cls1_q   <= '0;
      exp1_q   <= '0;
      frac1_q  <= '0;
      shift1_q <= '0;
      daz1_q   <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sign1_q  <= sign_in;
        cls1_q   <= cls_d;
        exp1_q   <= exp_in;
        frac1_q  <= frac_in;
        shift1_q <= shift_d;
        daz1_q   <= in_daz;
      end
    end
  end

  logic [NSIG-1:0]        frac_sh;
  logic [NSIG:0]          sig_d;
  logic signed [NEXP+1:0] exp_d;
  fp_class_t              flags_d;
  logic                   flushed_d;

  assign frac_sh = frac1_q << shift1_q;

  // Infinities and NaNs fall through the defaults, keeping the payload.
  always_comb begin
    sig_d     = {1'b1, frac1_q};
    exp_d     = SPEC_X;
    flags_d   = cls1_q;
    flushed_d = 1'b0;
    if (cls1_q[NORMAL]) begin
      exp_d = signed'((NEXP + 2)'(exp1_q)) - BIAS_X;
    end else if (cls1_q[SUBNORMAL] && !daz1_q) begin
      sig_d = {1'b1, frac_sh};
      exp_d = EMIN_X - signed'((NEXP + 2)'(shift1_q));
    end else if (cls1_q[ZERO] || cls1_q[SUBNORMAL]) begin
      sig_d     = '0;
      exp_d     = EMIN_X;
      flags_d   = class_bit(ZERO);
      flushed_d = cls1_q[SUBNORMAL];
    end
  end

  logic                   v2_q;
  logic                   sign2_q;
  logic [NSIG:0]          sig2_q;
  logic signed [NEXP+1:0] exp2_q;
  fp_class_t              flags2_q;
  logic                   flushed2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q       <= 1'b0;
      sign2_q    <= 1'b0;
      sig2_q     <= '0;
      exp2_q     <= '0;
      flags2_q   <= '0;
      flushed2_q <= 1'b0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q    <= sign1_q;
        sig2_q     <= sig_d;
        exp2_q     <= exp_d;
        flags2_q   <= flags_d;
        flushed2_q <= flushed_d;
      end
    end
  end

  assign out_valid   = v2_q;
  assign out_sign    = sign2_q;
  assign out_sig     = sig2_q;
  assign out_exp     = exp2_q;
  assign out_flags   = flags2_q;
  assign out_flushed = flushed2_q;

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe: default-width pipeline with a result
// scoreboard, plus two alternate-width instances for parameter coverage.
module tb_fp_class_pipe;

  localparam int EW = 26;
  localparam logic [5:0] F_INF  = 6'b000001;
  localparam logic [5:0] F_SNAN = 6'b000010;
  localparam logic [5:0] F_QNAN = 6'b000100;
  localparam logic [5:0] F_ZERO = 6'b001000;
  localparam logic [5:0] F_SUB  = 6'b010000;
  localparam logic [5:0] F_NRM  = 6'b100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic [15:0] in_data;
  logic        in_daz, in_valid, in_ready;
  logic        out_sign, out_flushed, out_valid, out_ready;
  logic [7:0]  out_sig;
  logic [9:0]  out_exp;
  logic [5:0]  out_flags;

  fp_class_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_daz(in_daz),
    .in_valid(in_valid), .in_ready(in_ready), .out_sign(out_sign),
    .out_sig(out_sig), .out_exp(out_exp), .out_flags(out_flags),
    .out_flushed(out_flushed), .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- NEXP=5 / NSIG=10 instance ----------------
  logic [15:0] in_data_b;
  logic        in_valid_b, in_ready_b, out_sign_b, out_flushed_b, out_valid_b;
  logic [10:0] out_sig_b;
  logic [6:0]  out_exp_b;
  logic [5:0]  out_flags_b;

  fp_class_pipe #(.NEXP(5), .NSIG(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_daz(1'b0),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_sign(out_sign_b),
    .out_sig(out_sig_b), .out_exp(out_exp_b), .out_flags(out_flags_b),
    .out_flushed(out_flushed_b), .out_valid(out_valid_b), .out_ready(1'b1)
  );

  // ---------------- NEXP=11 / NSIG=52 instance ----------------
  logic [63:0] in_data_c;
  logic        in_valid_c, in_ready_c, out_sign_c, out_flushed_c, out_valid_c;
  logic [52:0] out_sig_c;
  logic [12:0] out_exp_c;
  logic [5:0]  out_flags_c;

  fp_class_pipe #(.NEXP(11), .NSIG(52)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_daz(1'b0),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .out_sign(out_sign_c),
    .out_sig(out_sig_c), .out_exp(out_exp_c), .out_flags(out_flags_c),
    .out_flushed(out_flushed_c), .out_valid(out_valid_c), .out_ready(1'b1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs, prev_obs;
  logic          stall_seen = 1'b0;

  logic [15:0]   v_in[10];
  logic          v_daz[10];
  logic [EW-1:0] v_exp[10];

  assign obs = {out_sign, out_sig, out_exp, out_flags, out_flushed};

  function automatic logic [EW-1:0] pack(input logic s, input logic [7:0] sig,
                                         input logic [9:0] e, input logic [5:0] f,
                                         input logic fl);
    return {s, sig, e, f, fl};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_seen) check("stall_stable", 128'(obs), 128'(prev_obs));
      if (out_valid && out_ready) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_miss++;
          $error("FAIL unexpected_output observed=%0h expected=none", obs);
        end
        if (exp_q.size() != 0) check("result", 128'(obs), 128'(exp_q.pop_front()));
      end
      stall_seen = out_valid && !out_ready;
      prev_obs   = obs;
    end else begin
      stall_seen = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int idx, input bit push);
    int to;
    in_data  = v_in[idx];
    in_daz   = v_daz[idx];
    in_valid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!in_ready && to < 100) begin
      to++;
      @(negedge clk);
    end
    check("accept", 128'(in_ready), 128'(1'b1));
    if (push) exp_q.push_back(v_exp[idx]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while (exp_q.size() != 0 && to < 200) begin
      to++;
      @(negedge clk);
    end
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  longint t0;

  initial begin
    v_in[0] = 16'h3F80; v_daz[0] = 0; v_exp[0] = pack(0, 8'h80, 10'd0,       F_NRM,  0);
    v_in[1] = 16'hC000; v_daz[1] = 0; v_exp[1] = pack(1, 8'h80, 10'd1,       F_NRM,  0);
    v_in[2] = 16'h0001; v_daz[2] = 0; v_exp[2] = pack(0, 8'h80, 10'(-133),   F_SUB,  0);
    v_in[3] = 16'h0040; v_daz[3] = 0; v_exp[3] = pack(0, 8'h80, 10'(-127),   F_SUB,  0);
    v_in[4] = 16'h0001; v_daz[4] = 1; v_exp[4] = pack(0, 8'h00, 10'(-126),   F_ZERO, 1);
    v_in[5] = 16'h7F80; v_daz[5] = 0; v_exp[5] = pack(0, 8'h80, 10'd128,     F_INF,  0);
    v_in[6] = 16'h7F81; v_daz[6] = 0; v_exp[6] = pack(0, 8'h81, 10'd128,     F_SNAN, 0);
    v_in[7] = 16'h7FC0; v_daz[7] = 0; v_exp[7] = pack(0, 8'hC0, 10'd128,     F_QNAN, 0);
    v_in[8] = 16'h8000; v_daz[8] = 0; v_exp[8] = pack(1, 8'h00, 10'(-126),   F_ZERO, 0);
    v_in[9] = 16'hFFC1; v_daz[9] = 1; v_exp[9] = pack(1, 8'hC1, 10'd128,     F_QNAN, 0);

    in_data = '0; in_daz = 0; in_valid = 0; out_ready = 1;
    in_data_b = '0; in_valid_b = 0; in_data_c = '0; in_valid_c = 0;

    #2;
    check("reset_outputs",
          128'({out_valid, out_sign, out_sig, out_exp, out_flags, out_flushed, in_ready}),
          128'(28'd1));

    // First operand presented as reset releases; result after two edges.
    @(negedge clk);
    rst_n    = 1'b1;
    in_data  = v_in[0];
    in_daz   = v_daz[0];
    in_valid = 1'b1;
    exp_q.push_back(v_exp[0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_1", 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    check("latency_2", 128'(out_valid), 128'(1'b1));
    drain();

    // Directed vectors back to back: one accept per cycle.
    @(posedge clk);
    #1;
    t0 = $time;
    for (int i = 1; i < 10; i++) send(i, 1'b1);
    check("throughput", 128'($time - t0), 128'(90));
    drain();

    // Same vectors with random downstream backpressure.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i, 1'b1);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages holding operands.
    out_ready = 1'b0;
    send(5, 1'b0);
    send(6, 1'b0);
    @(negedge clk);
    check("pipe_full", 128'({out_valid, in_ready}), 128'(2'b10));
    rst_n = 1'b0;
    #1;
    check("reset_mid", 128'({out_valid, out_sig, out_flags, in_ready}), 128'(16'd1));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    send(7, 1'b1);
    drain();

    // Alternate widths: fraction of 1 gives EMIN - NSIG.
    @(posedge clk);
    #1;
    in_data_b = 16'h0001; in_valid_b = 1;
    in_data_c = 64'h1;    in_valid_c = 1;
    @(posedge clk);
    #1;
    in_valid_b = 0; in_valid_c = 0;
    @(posedge clk);
    #1;
    check("b_subnormal_min",
          128'({out_valid_b, out_sign_b, out_sig_b, out_exp_b, out_flags_b, out_flushed_b}),
          128'({1'b1, 1'b0, 11'h400, 7'(-24), F_SUB, 1'b0}));
    check("c_subnormal_min",
          128'({out_valid_c, out_sign_c, out_sig_c, out_exp_c, out_flags_c, out_flushed_c}),
          128'({1'b1, 1'b0, 53'h10000000000000, 13'(-1074), F_SUB, 1'b0}));

    in_data_b = 16'h3C00;             in_valid_b = 1;
    in_data_c = 64'hFFF0000000000000; in_valid_c = 1;
    @(posedge clk);
    #1;
    in_valid_b = 0; in_valid_c = 0;
    @(posedge clk);
    #1;
    check("b_normal_one",
          128'({out_valid_b, out_sign_b, out_sig_b, out_exp_b, out_flags_b, out_flushed_b}),
          128'({1'b1, 1'b0, 11'h400, 7'd0, F_NRM, 1'b0}));
    check("c_neg_inf",
          128'({out_valid_c, out_sign_c, out_sig_c, out_exp_c, out_flags_c, out_flushed_c}),
          128'({1'b1, 1'b1, 53'h10000000000000, 13'd1024, F_INF, 1'b0}));

    // ---------------- report ----------------
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
